vc_rr_arbiter: RTL and testbench
================================

Name: vc_rr_arbiter

Overview:
- Round-robin arbiter that drains NUM_VC virtual-channel FIFOs (FWFT head data, per-FIFO empty flag) into one shared downstream FIFO write port.
- Issues per-FIFO pops and a registered downstream write.
- Burst-limits each grant and honours downstream almost-full back-pressure.
- Sits between the per-VC FIFO bank and the shared egress FIFO.

Parameters:
- NUM_VC, 4, number of requesting FIFOs (power of two, 2..8)
- VC_W, 2, log2(NUM_VC); grant index width
- WORD_SIZE, 6, data word width in bits
- BURST_LEN, 4, maximum consecutive words granted to one VC before rotation (1..15)

Ports:
- clk  in  1  rising-edge clock
- reset_L  in  1  asynchronous active-low reset
- vc_empty  in  NUM_VC  per-VC FIFO empty flag, bit i = VC i
- vc_data  in  NUM_VC*WORD_SIZE  head word of each VC; VC i at bits [i*WORD_SIZE +: WORD_SIZE]
- dn_almost_full  in  1  downstream FIFO almost-full
- vc_pop  out  NUM_VC  combinational one-hot pop to the VC FIFOs
- dn_push  out  1  registered write strobe to the downstream FIFO
- dn_data  out  WORD_SIZE  registered write data
- grant_idx  out  VC_W  registered index of the current or last granted VC
- arb_busy  out  1  registered; high while in state GRANT

Behaviour:
- Reset is asynchronous, active-low. While reset_L=0:
  - state=IDLE, dn_push=0, dn_data=0, grant_idx=0, arb_busy=0.
  - Burst counter=0, rotation pointer=0.
  - vc_pop=0, forced combinationally.
- Eligibility: eligible = ~vc_empty & {NUM_VC{~dn_almost_full}}.
- Selection: first eligible VC searched upward from (rot_ptr) modulo NUM_VC, wrapping NUM_VC-1 -> 0.
- FSM states: IDLE, GRANT.
- IDLE:
  - vc_pop=0.
  - If any eligible: latch the selected index into grant_idx, burst_cnt<=0, go to GRANT.
  - The first pop happens in the first GRANT cycle.
- GRANT, with cur = grant_idx:
  - Pop condition: ~vc_empty[cur] & ~dn_almost_full. When it holds:
    - vc_pop[cur]=1 combinationally.
    - Next edge: dn_push<=1, dn_data<=vc_data[cur], burst_cnt<=burst_cnt+1.
  - Pop latency: pop in cycle N gives dn_push/dn_data valid in cycle N+1. dn_push is otherwise 0 at the next edge.
  - Burst end: the pop with burst_cnt==BURST_LEN-1.
    - rot_ptr<=cur+1 (mod NUM_VC).
    - If another eligible VC exists (including cur via wrap), regrant directly with no IDLE bubble: grant_idx<=new, burst_cnt<=0.
    - Otherwise go to IDLE.
  - VC empties mid-burst (vc_empty[cur]=1, no pop): rotate as at burst end, same cycle evaluation, no pop this cycle.
  - dn_almost_full=1 mid-burst:
    - No pop.
    - burst_cnt, grant_idx and state are held; the same VC resumes when back-pressure drops.
    - arb_busy stays 1.
- Downstream headroom: dn_almost_full must assert with ≥1 free entry, because one push may already be in flight.
- Single active VC: after each burst it is re-granted through the wrap.
  - No dead cycles.
  - Sustained throughput is 1 word/clk.
- Ignored inputs: vc_data of non-granted VCs is ignored; pops are never issued to an empty VC.
- Reset mid-burst: outputs clear immediately.
  - An in-flight dn_push is dropped.
  - The word already popped is lost; this is accepted, since reset also clears the FIFOs.
- Counter widths: burst_cnt is 4 bits; it never exceeds BURST_LEN-1.

Optional Feature:
- Macro: VC_ARB_GRANT_CNT_EN.
- Defined: adds output port grant_cnt, width NUM_VC*8.
  - One 8-bit saturating counter per VC, incremented on each vc_pop[i].
  - Saturates at 255.
  - Cleared by reset.
- Undefined: no port, no counters, no logic.

Decomposition:
- Package vc_arb_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - default BURST_LEN.
  - VC_W derivation helper constant.
- One sub-module: vc_rr_pick.
  - Combinational rotating priority picker.
  - Inputs: eligible vector, rot_ptr.
  - Outputs: found flag, index.
- FSM and datapath live in vc_rr_arbiter.

Test Plan:
- Reset release, vc_empty=4'b1111 -> state IDLE, vc_pop=0, dn_push=0, dn_data=0, grant_idx=0 indefinitely.
- All four VCs hold 8 words (VC i data = 6'h10+i), dn_almost_full=0 -> bursts of 4 per VC:
  - order VC0,1,2,3,0,1,2,3.
  - dn_push continuous after the first grant.
  - dn_data matches per burst.
- Only VC2 non-empty with 10 words -> 10 consecutive pops, back-to-back, no gap at the burst boundaries at pops 4 and 8.
- dn_almost_full=1 for 3 cycles after the 2nd pop of a VC1 burst -> no pops for those cycles, grant_idx stays 1, then 2 more VC1 pops before rotation.
- VC0 empties after 2 words while VC3 is non-empty -> rotation to VC3 in the same cycle; next VC0 grant only after VC3's burst.
- reset_L pulsed low asynchronously mid-burst (between edges) -> dn_push, arb_busy and vc_pop drop immediately; grant restarts from VC0 after release.

Source files
------------

// File: rtl/vc_arb_pkg.sv
// Shared types and constants for the virtual-channel round-robin arbiter:
// FSM state encoding, default sizing and the grant-index width helper.
package vc_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_VC    = 4;
    localparam int DEFAULT_BURST_LEN = 4;
    localparam int BURST_CNT_W       = 4;

    // Bits needed to index n channels; never less than one.
    function automatic int vc_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEFAULT_VC_W = vc_width(DEFAULT_NUM_VC);

endpackage

// File: rtl/vc_rr_arbiter_if.sv
// Bundle of the per-VC FIFO bank signals and the shared downstream write port.
// master = FIFO/egress environment side, slave = the arbiter.
interface vc_rr_arbiter_if #(
    parameter int NUM_VC    = 4,
    parameter int VC_W      = 2,
    parameter int WORD_SIZE = 6
);
    logic [NUM_VC-1:0]           vc_empty;
    logic [NUM_VC*WORD_SIZE-1:0] vc_data;
    logic                        dn_almost_full;
    logic [NUM_VC-1:0]           vc_pop;
    logic                        dn_push;
    logic [WORD_SIZE-1:0]        dn_data;
    logic [VC_W-1:0]             grant_idx;
    logic                        arb_busy;

    modport master (
        output vc_empty, vc_data, dn_almost_full,
        input  vc_pop, dn_push, dn_data, grant_idx, arb_busy
    );

    modport slave (
        input  vc_empty, vc_data, dn_almost_full,
        output vc_pop, dn_push, dn_data, grant_idx, arb_busy
    );
endinterface

// File: rtl/vc_rr_pick.sv
// Combinational rotating-priority picker: first set bit of eligible searched
// upward from rot_ptr, wrapping at NUM_VC (a power of two).
module vc_rr_pick #(
    parameter int NUM_VC = 4,
    parameter int VC_W   = 2
) (
    input  logic [NUM_VC-1:0] eligible,
    input  logic [VC_W-1:0]   rot_ptr,
    output logic              found,
    output logic [VC_W-1:0]   idx
);
    logic [VC_W-1:0]   cand [NUM_VC];
    logic [NUM_VC-1:0] rot_elig;

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_rot
            // Index arithmetic wraps naturally because NUM_VC == 2**VC_W.
            assign cand[gi]     = rot_ptr + VC_W'(gi);
            assign rot_elig[gi] = eligible[cand[gi]];
        end
    endgenerate

    always_comb begin
        found = |rot_elig;
        idx   = rot_ptr;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (rot_elig[k]) begin
                idx = cand[k];
            end
        end
    end
endmodule

// File: rtl/vc_rr_arbiter.sv
// Burst-limited round-robin drain of NUM_VC FWFT FIFOs into one egress FIFO.
// Define VC_ARB_GRANT_CNT_EN to add per-VC saturating pop counters (grant_cnt).
module vc_rr_arbiter
    import vc_arb_pkg::*;
#(
    parameter int NUM_VC    = DEFAULT_NUM_VC,
    parameter int VC_W      = vc_width(NUM_VC),
    parameter int WORD_SIZE = 6,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic                 clk,
    input  logic                 reset_L,
    vc_rr_arbiter_if.slave       bus
`ifdef VC_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_VC*8-1:0]  grant_cnt
`endif
);
    state_t                 state_reg, state_next;
    logic [VC_W-1:0]        grant_idx_reg, grant_idx_next;
    logic [VC_W-1:0]        rot_ptr_reg, rot_ptr_next;
    logic [BURST_CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic                   dn_push_reg, dn_push_next;
    logic [WORD_SIZE-1:0]   dn_data_reg, dn_data_next;

    logic [WORD_SIZE-1:0]   head [NUM_VC];
    logic [NUM_VC-1:0]      eligible;
    logic [NUM_VC-1:0]      pop_vec;
    logic [VC_W-1:0]        pick_ptr;
    logic [VC_W-1:0]        pick_idx;
    logic                   pick_found;
    logic                   pop_ok;
    logic                   burst_end;
    logic                   rotate;

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_head
            assign head[gi] = bus.vc_data[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    assign eligible  = ~bus.vc_empty & {NUM_VC{~bus.dn_almost_full}};
    assign pop_ok    = (state_reg == ST_GRANT) && !bus.vc_empty[grant_idx_reg] && !bus.dn_almost_full;
    assign burst_end = pop_ok && (burst_cnt_reg == BURST_CNT_W'(BURST_LEN - 1));
    assign rotate    = (state_reg == ST_GRANT) && (burst_end || bus.vc_empty[grant_idx_reg]);

    // On rotation the search starts just past the current VC in the same
    // cycle, so a regrant (possibly to the same VC) costs no idle bubble.
    assign pick_ptr = rotate ? (grant_idx_reg + VC_W'(1)) : rot_ptr_reg;

    vc_rr_pick #(
        .NUM_VC (NUM_VC),
        .VC_W   (VC_W)
    ) u_pick (
        .eligible (eligible),
        .rot_ptr  (pick_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_next     = state_reg;
        grant_idx_next = grant_idx_reg;
        rot_ptr_next   = rot_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        dn_push_next   = 1'b0;
        dn_data_next   = dn_data_reg;
        pop_vec        = '0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_idx_next = pick_idx;
                    burst_cnt_next = '0;
                    state_next     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (pop_ok) begin
                    pop_vec[grant_idx_reg] = 1'b1;
                    dn_push_next           = 1'b1;
                    dn_data_next           = head[grant_idx_reg];
                    burst_cnt_next         = burst_cnt_reg + BURST_CNT_W'(1);
                end
                if (rotate) begin
                    rot_ptr_next   = pick_ptr;
                    burst_cnt_next = '0;
                    if (pick_found) begin
                        grant_idx_next = pick_idx;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg     <= ST_IDLE;
            grant_idx_reg <= '0;
            rot_ptr_reg   <= '0;
            burst_cnt_reg <= '0;
            dn_push_reg   <= 1'b0;
            dn_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            grant_idx_reg <= grant_idx_next;
            rot_ptr_reg   <= rot_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            dn_push_reg   <= dn_push_next;
            dn_data_reg   <= dn_data_next;
        end
    end

    assign bus.vc_pop    = pop_vec & {NUM_VC{reset_L}};
    assign bus.dn_push   = dn_push_reg;
    assign bus.dn_data   = dn_data_reg;
    assign bus.grant_idx = grant_idx_reg;
    assign bus.arb_busy  = (state_reg == ST_GRANT);

`ifdef VC_ARB_GRANT_CNT_EN
    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_gcnt
            logic [7:0] cnt_reg;
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    cnt_reg <= '0;
                end else if (bus.vc_pop[gi] && (cnt_reg != 8'hFF)) begin
                    cnt_reg <= cnt_reg + 8'd1;
                end
            end
            assign grant_cnt[gi*8 +: 8] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Directed bench for vc_rr_arbiter: stimulus queues expected egress words and
// probes; a negedge monitor pops and compares them against the DUT.
module tb_vc_rr_arbiter;
    localparam int NUM_VC = 4;
    localparam int VC_W   = 2;
    localparam int WS     = 6;

    localparam int K_POP  = 0;
    localparam int K_GNT  = 1;
    localparam int K_BUSY = 2;
    localparam int K_PUSH = 3;
    localparam int K_DATA = 4;
    localparam int K_VAL  = 5;

    typedef struct {
        string name;
        int    kind;
        int    exp;
        int    act;
    } probe_t;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    vc_rr_arbiter_if #(.NUM_VC(NUM_VC), .VC_W(VC_W), .WORD_SIZE(WS)) bus ();

`ifdef VC_ARB_GRANT_CNT_EN
    logic [NUM_VC*8-1:0] grant_cnt;
`endif

    vc_rr_arbiter #(
        .NUM_VC    (NUM_VC),
        .VC_W      (VC_W),
        .WORD_SIZE (WS),
        .BURST_LEN (4)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .bus       (bus)
`ifdef VC_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    logic [WS-1:0] exp_q [$];
    probe_t        probe_q [$];
    int            checks   = 0;
    int            failures = 0;

    // FIFO-bank model and per-test pop statistics (stimulus side only)
    int         cnt [NUM_VC];
    bit         const_mode;
    int         cyc;
    int         pop_n;
    int         first_pop;
    int         last_pop;
    logic [3:0] last_pops;

    task automatic drive();
        for (int i = 0; i < NUM_VC; i++) begin
            bus.vc_empty[i] = (cnt[i] == 0);
            bus.vc_data[i*WS +: WS] = const_mode ? WS'(16 + i) : {2'(i), 4'(cnt[i])};
        end
    endtask

    task automatic cycle();
        logic [3:0] pops;
        @(negedge clk);
        pops = bus.vc_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_VC; i++) begin
            if (pops[i] && cnt[i] > 0) cnt[i]--;
        end
        cyc++;
        last_pops = pops;
        if (pops != 4'b0) begin
            pop_n++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        drive();
    endtask

    task automatic clr_stats();
        pop_n     = 0;
        first_pop = -1;
        last_pop  = -1;
    endtask

    task automatic probe(input string nm, input int kind, input int exp, input int act);
        probe_t p;
        p.name = nm;
        p.kind = kind;
        p.exp  = exp;
        p.act  = act;
        probe_q.push_back(p);
    endtask

    task automatic run_until_pops(input int n, input int budget, input string nm);
        int g;
        g = 0;
        while (pop_n < n && g < budget) begin
            cycle();
            g++;
        end
        probe(nm, K_VAL, n, pop_n);
    endtask

    task automatic drain_and_check(input string nm);
        repeat (4) cycle();
        probe(nm, K_VAL, 0, exp_q.size());
    endtask

    // Monitor: sole owner of the check/failure counters.
    initial begin
        probe_t        p;
        logic [WS-1:0] e;
        int            act;
        forever begin
            @(negedge clk);
            checks++;
            if (((bus.vc_pop & bus.vc_empty) != 4'b0) || !$onehot0(bus.vc_pop)) begin
                failures++;
                $display("FAIL pop_legal: vc_pop=%b vc_empty=%b, required one-hot pop to a non-empty VC",
                         bus.vc_pop, bus.vc_empty);
            end
            if (bus.dn_push) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_push: dn_data=%h, required no push", bus.dn_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("push dn_data=%h expected=%h", bus.dn_data, e);
                    if (bus.dn_data !== e) begin
                        failures++;
                        $display("FAIL dn_data: got %h, required %h", bus.dn_data, e);
                    end
                end
            end
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                case (p.kind)
                    K_POP:   act = int'(bus.vc_pop);
                    K_GNT:   act = int'(bus.grant_idx);
                    K_BUSY:  act = int'(bus.arb_busy);
                    K_PUSH:  act = int'(bus.dn_push);
                    K_DATA:  act = int'(bus.dn_data);
                    default: act = p.act;
                endcase
                checks++;
                if (act != p.exp) begin
                    failures++;
                    $display("FAIL %s: got %0d, required %0d", p.name, act, p.exp);
                end
            end
        end
    end

    initial begin
        reset_L = 1'b0;
        bus.dn_almost_full = 1'b0;
        const_mode = 1'b0;
        cyc = 0;
        last_pops = 4'b0;
        for (int i = 0; i < NUM_VC; i++) cnt[i] = 0;
        clr_stats();
        drive();
        cycle();
        cycle();
        reset_L = 1'b1;

        // 1: idle with all VCs empty
        probe("rst_vc_pop", K_POP, 0, 0);
        probe("rst_dn_push", K_PUSH, 0, 0);
        probe("rst_dn_data", K_DATA, 0, 0);
        probe("rst_grant_idx", K_GNT, 0, 0);
        probe("rst_arb_busy", K_BUSY, 0, 0);
        repeat (10) cycle();
        probe("idle_vc_pop", K_POP, 0, 0);
        probe("idle_dn_push", K_PUSH, 0, 0);
        probe("idle_grant_idx", K_GNT, 0, 0);
        probe("idle_arb_busy", K_BUSY, 0, 0);
        probe("idle_pop_count", K_VAL, 0, pop_n);

        // 2: all four VCs with 8 words, bursts of 4 in order 0,1,2,3,0,1,2,3
        const_mode = 1'b1;
        for (int i = 0; i < NUM_VC; i++) cnt[i] = 8;
        drive();
        clr_stats();
        for (int r = 0; r < 2; r++)
            for (int v = 0; v < NUM_VC; v++)
                repeat (4) exp_q.push_back(WS'(16 + v));
        run_until_pops(32, 60, "all_vc_pop_count");
        probe("all_vc_pop_span", K_VAL, 31, last_pop - first_pop);
        drain_and_check("all_vc_left_over");

        // 3: single active VC2, 10 back-to-back pops across burst boundaries
        const_mode = 1'b0;
        cnt[2] = 10;
        drive();
        clr_stats();
        for (int c = 10; c >= 1; c--) exp_q.push_back({2'd2, 4'(c)});
        run_until_pops(10, 40, "vc2_pop_count");
        probe("vc2_pop_span", K_VAL, 9, last_pop - first_pop);
        drain_and_check("vc2_left_over");

        // 4: almost-full for 3 cycles after the 2nd pop of a VC1 burst
        cnt[1] = 6;
        cnt[2] = 2;
        drive();
        clr_stats();
        exp_q.push_back(6'h16); exp_q.push_back(6'h15);
        exp_q.push_back(6'h14); exp_q.push_back(6'h13);
        exp_q.push_back(6'h22); exp_q.push_back(6'h21);
        exp_q.push_back(6'h12); exp_q.push_back(6'h11);
        run_until_pops(2, 20, "af_first_pops");
        bus.dn_almost_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            probe("af_hold_vc_pop", K_POP, 0, 0);
            probe("af_hold_grant_idx", K_GNT, 1, 0);
            probe("af_hold_arb_busy", K_BUSY, 1, 0);
            cycle();
        end
        bus.dn_almost_full = 1'b0;
        probe("af_pop_count_held", K_VAL, 2, pop_n);
        probe("af_resume_pop3", K_POP, 2, 0);
        cycle();
        probe("af_resume_pop4", K_POP, 2, 0);
        cycle();
        probe("af_rotate_vc2", K_POP, 4, 0);
        cycle();
        run_until_pops(8, 40, "af_pop_count");
        drain_and_check("af_left_over");

        // 5: VC0 empties after 2 words while VC3 waits
        cnt[0] = 2;
        drive();
        clr_stats();
        exp_q.push_back(6'h02); exp_q.push_back(6'h01);
        exp_q.push_back(6'h35); exp_q.push_back(6'h34);
        exp_q.push_back(6'h33); exp_q.push_back(6'h32);
        exp_q.push_back(6'h02); exp_q.push_back(6'h01);
        exp_q.push_back(6'h31);
        cycle();
        cnt[3] = 5;
        drive();
        probe("empty_first_grant", K_GNT, 0, 0);
        begin
            int last0;
            int first3;
            int g;
            last0 = -1;
            first3 = -1;
            g = 0;
            while (first3 < 0 && g < 20) begin
                cycle();
                g++;
                if (last_pops[0]) last0 = cyc;
                if (last_pops[3]) first3 = cyc;
            end
            probe("empty_rotate_gap", K_VAL, 2, first3 - last0);
        end
        cnt[0] = 2;
        drive();
        run_until_pops(9, 40, "empty_pop_count");
        drain_and_check("empty_left_over");

        // 6: asynchronous reset in the middle of a VC1 burst
        cnt[1] = 6;
        cnt[2] = 4;
        drive();
        clr_stats();
        exp_q.push_back(6'h16);
        run_until_pops(2, 20, "rst_mid_first_pops");
        #2;
        reset_L = 1'b0;
        probe("rst_mid_dn_push", K_PUSH, 0, 0);
        probe("rst_mid_arb_busy", K_BUSY, 0, 0);
        probe("rst_mid_vc_pop", K_POP, 0, 0);
        probe("rst_mid_grant_idx", K_GNT, 0, 0);
        for (int i = 0; i < NUM_VC; i++) cnt[i] = 0;
        cnt[0] = 2;
        cnt[1] = 3;
        drive();
        cycle();
        cycle();
        reset_L = 1'b1;
        clr_stats();
        exp_q.push_back(6'h02); exp_q.push_back(6'h01);
        exp_q.push_back(6'h13); exp_q.push_back(6'h12);
        exp_q.push_back(6'h11);
        cycle();
        probe("rst_restart_grant", K_GNT, 0, 0);
        probe("rst_restart_pop", K_POP, 1, 0);
        run_until_pops(5, 30, "rst_restart_pop_count");
        drain_and_check("rst_left_over");
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
